// File: rtl/fir_sequencer.sv
// fir_sequencer: control FSM for the FIR datapath behind the AHB-Lite slave.
// Loads the coefficient bank on coefficient confirmation and runs one
// NUM_TAPS-long multiply-accumulate pass per new sample. Every output is
// decoded from registered state; inputs only affect outputs via next state.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   data_ready        pulse: new sample written by slave
//   new_coeff_set     pulse: coefficient confirmation written
//   overflow          datapath overflow, only looked at during MAC cycles
//   coef_load         copy coefficient register coef_idx into datapath bank
//   coef_idx, tap_idx coefficient / sample-history select
//   sample_shift      push new sample into history
//   acc_clear, acc_en accumulator zero / accumulate
//   result_load       latch accumulator into result register
//   coeff_clear       clear confirmation register in slave
//   busy, err         status bits (err sticky until the next sequence starts)
//   sample_drop       pulse: a sample was lost
module fir_sequencer #(
  parameter int unsigned NUM_TAPS = 4,
  parameter int unsigned IDX_W    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             data_ready,
  input  logic             new_coeff_set,
  input  logic             overflow,
  output logic             coef_load,
  output logic [IDX_W-1:0] coef_idx,
  output logic [IDX_W-1:0] tap_idx,
  output logic             sample_shift,
  output logic             acc_clear,
  output logic             acc_en,
  output logic             result_load,
  output logic             coeff_clear,
  output logic             busy,
  output logic             err,
  output logic             sample_drop
);

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_TAPS - 1);

  typedef enum logic [2:0] {
    StIdle, StLoad, StClr, StShift, StMac, StDone, StErr
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             pend_coef_q, pend_coef_d;
  logic             pend_sample_q, pend_sample_d;
  logic             drop_q, drop_d;

  logic             dispatch;      // state may start a new sequence at this edge
  logic             coef_eff, samp_eff;
  logic             start_load, start_shift;
  logic [1:0]       samp_cnt;      // samples still outstanding after this edge

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    dispatch = 1'b0;
    // A pulse arriving on the very edge a sequence ends counts as pending, so
    // nothing is stranded in IDLE with a flag set.
    coef_eff = pend_coef_q | new_coeff_set;
    samp_eff = pend_sample_q | data_ready;

    case (state_q)
      StLoad: begin
        if (idx_q == LastIdx) begin
          state_d = StClr;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StShift: begin
        state_d = StMac;
        idx_d   = '0;
      end
      StMac: begin
        if (overflow) begin
          state_d = StErr;
          idx_d   = '0;
        end else if (idx_q == LastIdx) begin
          state_d = StDone;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: begin
        // IDLE, ERR, CLR, DONE: coefficient load wins over a sample
        dispatch = 1'b1;
        idx_d    = '0;
        if (coef_eff) begin
          state_d = StLoad;
        end else if (samp_eff) begin
          state_d = StShift;
        end else if (state_q == StErr) begin
          state_d = StErr;
        end else begin
          state_d = StIdle;
        end
      end
    endcase

    start_load  = dispatch & coef_eff;
    start_shift = dispatch & ~coef_eff & samp_eff;

    pend_coef_d   = coef_eff & ~start_load;
    samp_cnt      = {1'b0, pend_sample_q} + {1'b0, data_ready} - {1'b0, start_shift};
    pend_sample_d = |samp_cnt;
    // Two outstanding samples cannot both be held: one is lost.
    drop_d        = samp_cnt[1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      idx_q         <= '0;
      pend_coef_q   <= 1'b0;
      pend_sample_q <= 1'b0;
      drop_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      pend_coef_q   <= pend_coef_d;
      pend_sample_q <= pend_sample_d;
      drop_q        <= drop_d;
    end
  end

  always_comb begin
    coef_load    = 1'b0;
    coef_idx     = '0;
    tap_idx      = '0;
    sample_shift = 1'b0;
    acc_clear    = 1'b0;
    acc_en       = 1'b0;
    result_load  = 1'b0;
    coeff_clear  = 1'b0;
    busy         = 1'b0;
    err          = 1'b0;
    sample_drop  = drop_q;
    case (state_q)
      StLoad: begin
        coef_load = 1'b1;
        coef_idx  = idx_q;
        busy      = 1'b1;
      end
      StClr: begin
        coeff_clear = 1'b1;
        busy        = 1'b1;
      end
      StShift: begin
        sample_shift = 1'b1;
        acc_clear    = 1'b1;
        busy         = 1'b1;
      end
      StMac: begin
        acc_en   = 1'b1;
        tap_idx  = idx_q;
        coef_idx = idx_q;
        busy     = 1'b1;
      end
      StDone: begin
        result_load = 1'b1;
        busy        = 1'b1;
      end
      StErr: begin
        err = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fir_sequencer.sv
// Self-checking bench for fir_sequencer. The reference model plans each
// sequence as a list of per-cycle output words and tracks outstanding
// samples/coefficient requests as counts; a monitor compares every cycle.
module tb_fir_sequencer;

  localparam int unsigned NumTaps = 4;
  localparam int unsigned IdxW    = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            data_ready, new_coeff_set, overflow;
  logic            coef_load, sample_shift, acc_clear, acc_en;
  logic            result_load, coeff_clear, busy, err, sample_drop;
  logic [IdxW-1:0] coef_idx, tap_idx;

  fir_sequencer #(.NUM_TAPS(NumTaps), .IDX_W(IdxW)) dut (
    .clk          (clk),
    .rst          (rst),
    .data_ready   (data_ready),
    .new_coeff_set(new_coeff_set),
    .overflow     (overflow),
    .coef_load    (coef_load),
    .coef_idx     (coef_idx),
    .tap_idx      (tap_idx),
    .sample_shift (sample_shift),
    .acc_clear    (acc_clear),
    .acc_en       (acc_en),
    .result_load  (result_load),
    .coeff_clear  (coeff_clear),
    .busy         (busy),
    .err          (err),
    .sample_drop  (sample_drop)
  );

  always #5 clk = ~clk;

  // Output word: [12]coef_load [11:10]coef_idx [9:8]tap_idx [7]sample_shift
  // [6]acc_clear [5]acc_en [4]result_load [3]coeff_clear [2]busy [1]err [0]drop
  logic [12:0] dut_vec;
  assign dut_vec = {coef_load, coef_idx, tap_idx, sample_shift, acc_clear, acc_en,
                    result_load, coeff_clear, busy, err, sample_drop};

  localparam logic [12:0] IdleV = 13'b0;
  localparam logic [12:0] ErrV  = 13'b0_00_00_0000_0_0_1_0;
  localparam logic [12:0] DropB = 13'b1;

  function automatic logic [12:0] mkv(bit cl, int ci, int ti, bit ss, bit ac, bit ae,
                                      bit rl, bit cc);
    logic [1:0] c2, t2;
    c2 = 2'(ci);
    t2 = 2'(ti);
    return {cl, c2, t2, ss, ac, ae, rl, cc, 1'b1, 1'b0, 1'b0};
  endfunction

  int          errors = 0;
  int          checks = 0;
  logic [12:0] exp_q[$];
  logic [12:0] plan[$];
  logic [12:0] cur;
  int          pend_s;
  bit          pend_c;

  task automatic check(string name, logic [12:0] got, logic [12:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%b exp=%b", name, $time, got, exp);
    end
  endtask

  // Monitor: one expected word per cycle, compared just after the edge.
  always @(posedge clk) begin
    logic [12:0] e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("outputs", dut_vec, e);
    end
  end

  task automatic model_reset();
    plan.delete();
    cur    = IdleV;
    pend_s = 0;
    pend_c = 1'b0;
  endtask

  // Drive one cycle of inputs and push the word expected after the next edge.
  task automatic step(bit dr, bit ncs, bit ov);
    int          samples;
    bit          coefs;
    logic [12:0] nxt;
    @(negedge clk);
    data_ready    = dr;
    new_coeff_set = ncs;
    overflow      = ov;
    samples = pend_s + int'(dr);
    coefs   = pend_c | ncs;
    if (cur[5] && ov) begin
      plan.delete();
      nxt = ErrV;
    end else if (plan.size() > 0) begin
      nxt = plan.pop_front();
    end else if (coefs) begin
      for (int k = 0; k < NumTaps; k++) plan.push_back(mkv(1, k, 0, 0, 0, 0, 0, 0));
      plan.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 1));
      nxt   = plan.pop_front();
      coefs = 1'b0;
    end else if (samples > 0) begin
      plan.push_back(mkv(0, 0, 0, 1, 1, 0, 0, 0));
      for (int k = 0; k < NumTaps; k++) plan.push_back(mkv(0, k, k, 0, 0, 1, 0, 0));
      plan.push_back(mkv(0, 0, 0, 0, 0, 0, 1, 0));
      nxt = plan.pop_front();
      samples--;
    end else begin
      nxt = (cur == ErrV) ? ErrV : IdleV;
    end
    pend_c = coefs;
    pend_s = (samples > 0) ? 1 : 0;
    cur    = nxt;
    exp_q.push_back((samples >= 2) ? (nxt | DropB) : nxt);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 0, 0);
  endtask

  initial begin
    rst = 1'b1;
    data_ready = 1'b0;
    new_coeff_set = 1'b0;
    overflow = 1'b0;
    model_reset();
    #2;
    check("reset_held", dut_vec, IdleV);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_released", dut_vec, IdleV);

    // Coefficient load from IDLE.
    step(0, 1, 0); idle(6);
    // Single sample.
    step(1, 0, 0); idle(7);
    // Overflow in MAC[1], then recovery with a full pass.
    step(1, 0, 0); idle(2); step(0, 0, 1); idle(3);
    step(1, 0, 0); idle(7);
    // Back-to-back: sample during MAC[0], another during MAC[2] -> drop.
    step(1, 0, 0); step(0, 0, 0); step(1, 0, 0); step(0, 0, 0); step(1, 0, 0);
    idle(14);
    // Simultaneous coefficient confirmation and sample in IDLE.
    step(1, 1, 0); idle(13);

    // Asynchronous reset in the middle of MAC[2].
    step(1, 0, 0); idle(3);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("reset_mid_pass", dut_vec, IdleV);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    idle(4);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 5) == 0, $urandom_range(0, 29) == 0,
           $urandom_range(0, 7) == 0);
    end
    idle(12);

    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d left exp=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
